// File: rtl/fp32_to_fixed_quantizer.sv
// fp32 -> signed fixed-point quantizer: decode, shift, round, then negate/saturate.
// Fixed 3-cycle latency, no backpressure, with a saturating count of saturated results.
module fp32_to_fixed_quantizer #(
    parameter int OUT_WIDTH     = 8,
    parameter int FRAC_BITS     = 0,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     fp_value_rdy,
    input  logic [31:0]              fp_value,
    input  logic                     clear_stats,
    output logic                     result_rdy,
    output logic [OUT_WIDTH-1:0]     result,
    output logic                     result_sat,
    output logic [SAT_CNT_WIDTH-1:0] sat_count
);
    localparam int STAGES = 3;
    localparam int MW     = OUT_WIDTH + 1;   // magnitude after shift
    localparam int RW     = OUT_WIDTH + 2;   // magnitude after rounding
    localparam int WIDE   = OUT_WIDTH + 25;  // shift workspace, wide enough to see lost bits

    localparam logic signed [9:0]   K_MAX   = 10'(OUT_WIDTH);
    localparam logic [RW-1:0]       POS_LIM = RW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic [RW-1:0]       NEG_LIM = RW'(1 << (OUT_WIDTH - 1));
    localparam logic [OUT_WIDTH-1:0] MAX_OUT = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_OUT = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_NORM} cls_e;

    typedef struct packed {
        cls_e              cls;
        logic              sign;
        logic [23:0]       sig;
        logic signed [9:0] k;
    } s1_t;

    typedef struct packed {
        cls_e          cls;
        logic          sign;
        logic          ovf;
        logic [MW-1:0] mag;
        logic          rnd;
    } s2_t;

    typedef struct packed {
        cls_e          cls;
        logic          sign;
        logic          ovf;
        logic [RW-1:0] mag;
    } s3_t;

    logic [STAGES:0]         vld_pipe_q, vld_pipe_d;
    s1_t                     s1_q, s1_d;
    s2_t                     s2_q, s2_d;
    s3_t                     s3_q, s3_d;
    logic [OUT_WIDTH-1:0]    result_q, result_d;
    logic                    result_sat_q, result_sat_d;
    logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

    logic [9:0]      k_abs;
    logic [24:0]     ext;
    logic [WIDE-1:0] wide;
    logic [RW-1:0]   neg_mag;

    // Data stages advance every cycle; only the valid bits say whether they matter.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-1:0], fp_value_rdy};
    end

    // Stage 1: classify and form the signed shift k = e - 150 + FRAC_BITS.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = fp_value[31];
        s1_d.sig  = {1'b1, fp_value[22:0]};
        s1_d.k    = $signed({2'b00, fp_value[30:23]}) - 10'sd150 + $signed(10'(FRAC_BITS));
        if (fp_value[30:23] == 8'd0)
            s1_d.cls = CLS_ZERO;
        else if (fp_value[30:23] == 8'hFF)
            s1_d.cls = (fp_value[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
        else
            s1_d.cls = CLS_NORM;
    end

    // Stage 2: align the significand; right shifts keep the first discarded bit for rounding.
    always_comb begin
        s2_d      = '0;
        s2_d.cls  = s1_q.cls;
        s2_d.sign = s1_q.sign;
        k_abs     = '0;
        ext       = '0;
        wide      = '0;
        if (!s1_q.k[9]) begin
            if (s1_q.k >= K_MAX)
                s2_d.ovf = 1'b1;
            else
                wide = WIDE'(s1_q.sig) << s1_q.k[4:0];
        end else begin
            k_abs = $unsigned(-s1_q.k);
            if (k_abs <= 10'd24) begin
                ext      = {s1_q.sig, 1'b0} >> k_abs;
                wide     = WIDE'(ext[24:1]);
                s2_d.rnd = ext[0];
            end
        end
        s2_d.ovf = s2_d.ovf | (|wide[WIDE-1:MW]);
        s2_d.mag = wide[MW-1:0];
    end

    // Stage 3: round half away from zero by adding the round bit to the magnitude.
    always_comb begin
        s3_d      = '0;
        s3_d.cls  = s2_q.cls;
        s3_d.sign = s2_q.sign;
        s3_d.ovf  = s2_q.ovf;
        s3_d.mag  = RW'(s2_q.mag) + RW'(s2_q.rnd);
    end

    // Output: apply sign and clamp; the negative bound is one larger than the positive one.
    always_comb begin
        result_d     = result_q;
        result_sat_d = result_sat_q;
        neg_mag      = -s3_q.mag;
        if (vld_pipe_q[STAGES-1]) begin
            case (s3_q.cls)
                CLS_ZERO: begin
                    result_d     = '0;
                    result_sat_d = 1'b0;
                end
                CLS_INF: begin
                    result_d     = s3_q.sign ? MIN_OUT : MAX_OUT;
                    result_sat_d = 1'b1;
                end
                CLS_NAN: begin
                    result_d     = '0;
                    result_sat_d = 1'b1;
                end
                default: begin
                    if (s3_q.sign) begin
                        if (s3_q.ovf || s3_q.mag > NEG_LIM) begin
                            result_d     = MIN_OUT;
                            result_sat_d = 1'b1;
                        end else begin
                            result_d     = neg_mag[OUT_WIDTH-1:0];
                            result_sat_d = 1'b0;
                        end
                    end else begin
                        if (s3_q.ovf || s3_q.mag > POS_LIM) begin
                            result_d     = MAX_OUT;
                            result_sat_d = 1'b1;
                        end else begin
                            result_d     = s3_q.mag[OUT_WIDTH-1:0];
                            result_sat_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Counts the saturated result visible this cycle; clear wins and drops that event.
    always_comb begin
        sat_count_d = sat_count_q;
        if (clear_stats)
            sat_count_d = '0;
        else if (vld_pipe_q[STAGES] && result_sat_q && (sat_count_q != '1))
            sat_count_d = sat_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_q   <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            result_q     <= '0;
            result_sat_q <= 1'b0;
            sat_count_q  <= '0;
        end else begin
            vld_pipe_q   <= vld_pipe_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            result_q     <= result_d;
            result_sat_q <= result_sat_d;
            sat_count_q  <= sat_count_d;
        end
    end

    assign result_rdy = vld_pipe_q[STAGES];
    assign result     = result_q;
    assign result_sat = result_sat_q;
    assign sat_count  = sat_count_q;
endmodule

// File: tb/tb_fp32_to_fixed_quantizer.sv
// Bench for fp32_to_fixed_quantizer: two instances (FRAC_BITS 0 and 4) against a real-arithmetic model.
module tb_fp32_to_fixed_quantizer;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        vin = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] fin = 32'd0;
    logic        rdy0, rdy1, sat0, sat1;
    logic [7:0]  r0, r1;
    logic [15:0] c0, c1;

    always #5 clk = ~clk;

    fp32_to_fixed_quantizer #(.OUT_WIDTH(8), .FRAC_BITS(0), .SAT_CNT_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .fp_value_rdy(vin), .fp_value(fin), .clear_stats(clr),
        .result_rdy(rdy0), .result(r0), .result_sat(sat0), .sat_count(c0));

    fp32_to_fixed_quantizer #(.OUT_WIDTH(8), .FRAC_BITS(4), .SAT_CNT_WIDTH(16)) dut_f4 (
        .clk(clk), .rstn(rstn), .fp_value_rdy(vin), .fp_value(fin), .clear_stats(clr),
        .result_rdy(rdy1), .result(r1), .result_sat(sat1), .sat_count(c1));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact real value, round half away from zero, clamp to int8.
    function automatic logic [8:0] ref_q(input logic [31:0] f, input int fb);
        int  e;
        real r, mg;
        e = int'(f[30:23]);
        if (e == 0) return 9'h000;
        if (e == 255) return (f[22:0] == 23'd0) ? {1'b1, (f[31] ? 8'h80 : 8'h7F)} : 9'h100;
        r  = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127 + fb));
        mg = $floor(r + 0.5);
        if (!f[31]) begin
            if (mg > 127.0) return 9'h17F;
            return {1'b0, 8'(int'(mg))};
        end
        if (mg > 128.0) return 9'h180;
        return {1'b0, 8'(-int'(mg))};
    endfunction

    // Model state: inputs sampled at the last four edges, last results, stats.
    bit          hv[4];
    logic [31:0] hval[4];
    bit          hdir[4];
    logic [8:0]  hexp[4];
    logic [7:0]  last_r[2];
    bit          last_s[2];
    bit          prev_os[2];
    int          cnt[2];
    bit          cur_dir = 1'b0;
    logic [8:0]  cur_exp = 9'h000;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            hv[i] = 1'b0; hval[i] = 32'd0; hdir[i] = 1'b0; hexp[i] = 9'h000;
        end
        for (int d = 0; d < 2; d++) begin
            last_r[d] = 8'h00; last_s[d] = 1'b0; prev_os[d] = 1'b0; cnt[d] = 0;
        end
    endtask

    task automatic check_outs();
        chk("rdy0", 32'(rdy0), 32'(hv[3]));
        chk("res0", 32'(r0), 32'(last_r[0]));
        chk("sat0", 32'(sat0), 32'(last_s[0]));
        chk("cnt0", 32'(c0), 32'(cnt[0]));
        chk("rdy4", 32'(rdy1), 32'(hv[3]));
        chk("res4", 32'(r1), 32'(last_r[1]));
        chk("sat4", 32'(sat1), 32'(last_s[1]));
        chk("cnt4", 32'(c1), 32'(cnt[1]));
    endtask

    task automatic step(input bit v, input logic [31:0] f, input bit c);
        logic [8:0] q;
        vin = v; fin = f; clr = c;
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            hv[i] = hv[i-1]; hval[i] = hval[i-1]; hdir[i] = hdir[i-1]; hexp[i] = hexp[i-1];
        end
        hv[0] = v; hval[0] = f; hdir[0] = cur_dir && v; hexp[0] = cur_exp;
        cur_dir = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (c) cnt[d] = 0;
            else if (prev_os[d] && cnt[d] < 65535) cnt[d]++;
            if (hv[3]) begin
                q = ref_q(hval[3], (d == 0) ? 0 : 4);
                last_s[d] = q[8];
                last_r[d] = q[7:0];
            end
            prev_os[d] = hv[3] && last_s[d];
        end
        check_outs();
        if (hdir[3]) chk("tbl0", {23'd0, sat0, r0}, {23'd0, hexp[3]});
    endtask

    // Directed value with an expected FRAC_BITS=0 result written out by hand.
    task automatic step_d(input logic [31:0] f, input logic [8:0] e0);
        cur_dir = 1'b1;
        cur_exp = e0;
        step(1'b1, f, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'hDEAD_BEEF, 1'b0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: begin
                case ($urandom_range(0, 3))
                    0: v = 32'h7F80_0000;
                    1: v = 32'hFF80_0000;
                    2: v = {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
                    default: v = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
                endcase
            end
            1: v = $urandom;
            default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(115, 140)), 23'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        model_reset();
        #3;
        check_outs();
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        step_d(32'h3F80_0000, 9'h001);
        step_d(32'hC300_0000, 9'h080);
        step_d(32'h4020_0000, 9'h003);
        step_d(32'hC020_0000, 9'h0FD);
        step_d(32'h3F00_0000, 9'h001);
        step_d(32'h3ECC_CCCD, 9'h000);
        step_d(32'h4348_0000, 9'h17F);
        step_d(32'hC301_0000, 9'h180);
        step_d(32'h7F80_0000, 9'h17F);
        step_d(32'h7FC0_0000, 9'h100);
        step_d(32'h0000_0001, 9'h000);
        step_d(32'h8000_0000, 9'h000);
        idle(5);
        chk("cnt_after_specials", 32'(c0), 32'd4);

        // FRAC_BITS=4 cases through the second instance.
        step(1'b1, 32'h3FC0_0000, 1'b0);
        idle(3);
        chk("f4_1p5", {23'd0, sat1, r1}, 32'h018);
        step(1'b1, 32'h4200_0000, 1'b0);
        idle(3);
        chk("f4_32", {23'd0, sat1, r1}, 32'h17F);

        step(1'b1, 32'h0000_0000, 1'b1);
        idle(4);
        for (int i = 0; i < 10; i++) step(1'b1, (i % 2) ? 32'hC400_0000 : 32'h4348_0000, 1'b0);
        idle(5);
        chk("cnt_stream10", 32'(c0), 32'd10);

        // Clear in the same cycle a saturated result is on the output.
        step(1'b1, 32'h7F80_0000, 1'b0);
        idle(2);
        step(1'b0, 32'd0, 1'b0);
        chk("sat_visible", 32'({rdy0, sat0}), 32'd3);
        step(1'b0, 32'd0, 1'b1);
        chk("clear_prio", 32'(c0), 32'd0);
        idle(2);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 4) != 0), rand_fp(), ($urandom_range(0, 30) == 0));
        idle(4);

        // Reset with two values in flight.
        step(1'b1, 32'h4348_0000, 1'b0);
        step(1'b1, 32'hC348_0000, 1'b0);
        vin = 1'b0;
        #2 rstn = 1'b0;
        model_reset();
        #1;
        check_outs();
        @(negedge clk);
        rstn = 1'b1;
        idle(6);
        chk("post_rst_cnt", 32'(c0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp32_to_fixed_quantizer.md
Name: fp32_to_fixed_quantizer

Overview:
- Pipelined converter that consumes the fp32 product stream of the fp32 multiplier stage and emits signed fixed-point values of configurable width and fractional bits.
- Used to quantize DNN activations after multiplication; sits directly downstream of the multiplier.
- Has no backpressure, like its upstream stage: accepts one value per cycle and produces results at fixed latency.
- Tracks saturation events in a statistics counter.

Parameters:
- OUT_WIDTH, 8, output integer width in bits (two's complement), legal 4..24.
- FRAC_BITS, 0, fractional bits of output format, legal 0..OUT_WIDTH-1.
- SAT_CNT_WIDTH, 16, width of saturation counter.

Ports:
- clk  in  1  clock; all state rises on posedge.
- rstn  in  1  asynchronous active-low reset.
- fp_value_rdy  in  1  input valid strobe (connects to multiplier result_rdy).
- fp_value  in  32  IEEE-754 binary32 input (connects to multiplier result).
- clear_stats  in  1  synchronous clear of sat_count.
- result_rdy  out  1  output valid strobe.
- result  out  OUT_WIDTH  signed fixed-point result.
- result_sat  out  1  result was saturated or NaN-forced; qualified by result_rdy.
- sat_count  out  SAT_CNT_WIDTH  saturating count of results with result_sat=1.

Behaviour:
- Reset (rstn=0, async): result_rdy=0, result=0, result_sat=0, sat_count=0, all pipeline valid bits 0. Reset mid-stream drops all in-flight values; no result_rdy pulse appears for them after release.
- Latency: exactly 3 cycles. Valid input sampled at edge t gives result_rdy=1 for one cycle after edge t+3. Back-to-back inputs give back-to-back outputs. result/result_sat hold their last value when result_rdy=0.
- Decode: s=fp_value[31], e=fp_value[30:23], m=fp_value[22:0].
  - e=0 means zero; denormals are flushed to zero. Output 0, not saturated. Sign is ignored, so -0 gives 0.
  - e=255 with m=0 (inf): output saturated to the signed bound, sat=1.
  - e=255 with m!=0 (NaN): output 0, sat=1.
- Value: round((-1)^s * 1.m * 2^(e-127) * 2^FRAC_BITS).
- Stage 1: register class (zero/inf/nan/normal), sign, 24-bit significand {1,m}, and signed shift k = e-127+FRAC_BITS-23.
- Stage 2 (magnitude shift):
  - k>=0: left shift into an OUT_WIDTH+1-bit magnitude. Overflow is flagged if any bit is lost or k>=OUT_WIDTH.
  - k<0: right shift by -k, keeping the round bit (first discarded bit). For -k>24 the magnitude and round bit are 0.
- Rounding: round-to-nearest, ties away from zero. Magnitude+round bit; sticky bits are not needed.
- Stage 3 (round, negate, saturate):
  - Positive: magnitude > 2^(OUT_WIDTH-1)-1 → result=2^(OUT_WIDTH-1)-1, sat=1.
  - Negative: magnitude > 2^(OUT_WIDTH-1) → result=-2^(OUT_WIDTH-1), sat=1.
  - Negative magnitude exactly 2^(OUT_WIDTH-1) is representable, sat=0.
  - Otherwise result=±magnitude.
- sat_count:
  - Increments by 1 on each cycle with result_rdy=1 and result_sat=1.
  - Sticks at all-ones and does not wrap.
  - clear_stats=1 sets it to 0 next edge and takes priority over a simultaneous increment; that event is not counted.
- Invalid-input cycles still advance the data pipeline (don't-care contents) but never assert result_rdy or touch sat_count.

Test Plan (OUT_WIDTH=8, FRAC_BITS=0 unless stated):
- Exact values: 0x3F800000 (1.0) → 0x01; 0xC3000000 (-128.0) → 0x80, sat=0. Each result_rdy arrives exactly 3 cycles after fp_value_rdy.
- Rounding: 0x40200000 (2.5) → 0x03; 0xC0200000 (-2.5) → 0xFD; 0x3F000000 (0.5) → 0x01; 0x3ECCCCCD (0.4) → 0x00.
- Saturation/specials: 0x43480000 (200.0) → 0x7F, sat=1; 0xC3010000 (-129.0) → 0x80, sat=1; 0x7F800000 → 0x7F, sat=1; 0x7FC00000 → 0x00, sat=1; 0x00000001 (denormal) → 0x00, sat=0. After this sequence sat_count=4.
- FRAC_BITS=4: 0x3FC00000 (1.5) → 0x18; 0x42000000 (32.0) → 0x7F, sat=1.
- Streaming and stats: 10 back-to-back saturating inputs → 10 consecutive result_rdy pulses and sat_count=10. Assert clear_stats in the same cycle as a saturated result → sat_count=0 next cycle.
- Reset: pull rstn low mid-stream with 2 values in flight, release → no result_rdy for them; sat_count=0 and all outputs at their reset values.
